// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: registered a+b+c_in ripple adder; ports clk, rst, in_valid, a, b, c_in -> s, c_out, carries, overflow, out_valid
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [WIDTH-1:0] carries,
  output logic             overflow,
  output logic             out_valid
);
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction
  logic [WIDTH-1:0] sum_c, cy_c;
  logic             c, c_msb;
  always_comb begin
    c = c_in;
    c_msb = c_in;
    sum_c = '0;
    cy_c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      c_msb = (k == WIDTH - 1) ? c : c_msb;
      {c, sum_c[k]} = full_add(a[k], b[k], c);
      cy_c[k] = c;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      c_out <= 1'b0;
      carries <= '0;
      overflow <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= sum_c;
        c_out <= c;
        carries <= cy_c;
        overflow <= c ^ c_msb;
      end
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed-vector bench for the 8-bit registered ripple adder
module tb_ripple_carry_adder;
  logic       clk = 1'b0;
  logic       rst, in_valid, c_in;
  logic [7:0] a, b;
  logic [7:0] s, carries;
  logic       c_out, overflow, out_valid;
  int         n_asserts = 0;
  int         n_fail = 0;
  ripple_carry_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .s(s), .c_out(c_out), .carries(carries), .overflow(overflow), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y, input logic ci);
    rst = r;
    in_valid = v;
    a = x;
    b = y;
    c_in = ci;
    @(posedge clk);
    #1;
  endtask
  task automatic res(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    chk({tag, ".s"}, 64'(s), 64'(es));
    chk({tag, ".c_out"}, 64'(c_out), 64'(ec));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    res("reset", 0, 0, 0);
    chk("reset.carries", 64'(carries), 0);
    chk("reset.overflow", 64'(overflow), 0);
    step(0, 1, 3, 2, 0);  res("3+2", 5, 0, 1);
    chk("3+2.carries", 64'(carries), 64'h02);
    step(0, 1, 1, 4, 0);  res("1+4", 5, 0, 1);
    step(0, 1, 0, 7, 1);  res("0+7+1", 8, 0, 1);
    step(0, 1, 3, 1, 0);  res("3+1", 4, 0, 1);
    step(0, 1, 3, 9, 1);  res("3+9+1", 13, 0, 1);
    step(0, 1, 3, 2, 1);  res("3+2+1", 6, 0, 1);
    step(0, 1, 12, 3, 0); res("12+3", 15, 0, 1);
    step(0, 1, 14, 1, 1); res("14+1+1", 16, 0, 1);
    step(0, 1, 0, 13, 0); res("0+13", 13, 0, 1);
    step(0, 1, 1, 9, 1);  res("1+9+1", 11, 0, 1);
    step(0, 1, 0, 0, 0);  res("0+0+0", 0, 0, 1);
    chk("0+0+0.carries", 64'(carries), 0);
    step(0, 1, 255, 0, 1); res("255+0+1", 0, 1, 1);
    chk("255+0+1.carries", 64'(carries), 64'hFF);
    step(0, 1, 255, 255, 1); res("255+255+1", 255, 1, 1);
    step(0, 1, 200, 100, 0); res("200+100", 44, 1, 1);
    step(0, 1, 127, 1, 0); res("127+1", 128, 0, 1);
    chk("127+1.overflow", 64'(overflow), 1);
    chk("127+1.carries", 64'(carries), 64'h7F);
    step(0, 1, 128, 128, 0); res("128+128", 0, 1, 1);
    chk("128+128.overflow", 64'(overflow), 1);
    chk("128+128.carries", 64'(carries), 64'h80);
    step(0, 1, 100, 27, 0); res("100+27", 127, 0, 1);
    chk("100+27.overflow", 64'(overflow), 0);
    chk("100+27.carries", 64'(carries), 0);
    step(0, 1, 3, 2, 0);  res("hold_pre", 5, 0, 1);
    step(0, 0, 99, 99, 0); res("hold", 5, 0, 0);
    step(0, 0, 99, 99, 1); res("hold2", 5, 0, 0);
    step(0, 1, 20, 30, 0); res("resume", 50, 0, 1);
    step(1, 1, 50, 50, 0); res("mid_rst", 0, 0, 0);
    chk("mid_rst.carries", 64'(carries), 0);
    chk("mid_rst.overflow", 64'(overflow), 0);
    step(0, 1, 50, 50, 0); res("after_rst", 100, 0, 1);
    step(0, 0, 0, 0, 0);  res("idle", 100, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised unsigned binary adder: `s = a + b + c_in`, with carry-out.
- Built as an explicit ripple chain of 1-bit full-adder cells.
- The result, carry-out and valid flag are registered, giving one-cycle latency.
- Serves as the basic arithmetic leaf in datapaths that need a clocked, resettable add with carry-in/carry-out chaining.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands on a/b/c_in are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- s  output  WIDTH  registered sum bits.
- c_out  output  1  registered carry out of bit WIDTH-1.
- carries  output  WIDTH  registered internal carry vector; bit i is the carry out of cell i, so `carries[WIDTH-1] == c_out`.
- overflow  output  1  registered signed overflow, equal to `carry[WIDTH-1] XOR carry[WIDTH-2]`; when WIDTH=1, equal to `c_out XOR c_in`.
- out_valid  output  1  registered result valid.

Behaviour:
- Full-adder cell i:
  - `sum_i = a[i] ^ b[i] ^ cin_i`
  - `cout_i = (a[i]&b[i]) | (a[i]&cin_i) | (b[i]&cin_i)`
  - `cin_0 = c_in`; `cin_(i+1) = cout_i`.
  - The chain is pure combinational ripple: no lookahead and no pipeline registers inside the chain.
- Arithmetic:
  - `{c_out, s} = a + b + c_in`, exact over WIDTH+1 bits.
  - The sum wraps modulo 2^WIDTH, with the lost bit appearing on c_out.
- Latency:
  - Operands sampled at rising edge N appear on s/c_out/carries/overflow/out_valid after edge N, stable for the whole cycle N+1.
  - Fixed latency of 1; throughput of one add per cycle.
- Valid handling:
  - `out_valid <= in_valid` every cycle.
  - When in_valid=0, the result registers hold their previous value: no update, and no X propagation from undriven operands.
  - No backpressure: the consumer must accept out_valid when it is asserted.
- Reset:
  - When rst=1 at a rising edge: s=0, c_out=0, carries=0, overflow=0, out_valid=0.
  - Reset takes priority over in_valid.
  - Reset asserted mid-stream discards the operand sampled that edge; the first valid result after reset requires in_valid at an edge where rst=0.
- Boundary conditions:
  - All-ones + 0 + c_in=1 gives s=0 and c_out=1, with the carry rippling through all WIDTH cells.
  - 0 + 0 + 0 gives s=0 and c_out=0.
  - All-ones + all-ones + 1 gives s=all-ones and c_out=1.
- Outputs are driven only by registers, with no combinational path from inputs to outputs.

Test Plan:
- Reset then sequence: (a=3,b=2,c_in=0), (1,4,0), (0,7,1), (3,1,0), (3,9,1), (3,2,1), one per cycle with in_valid=1 -> one cycle later each gives s=5, 5, 8, 4, 13, 6, all with c_out=0 and out_valid=1.
- Sequence (12,3,0), (14,1,1), (0,13,0), (1,9,1) -> s=15, 16, 13, 11, with c_out=0.
- Full ripple and wrap: (255,0,1) -> s=0, c_out=1, carries=0xFF; (255,255,1) -> s=255, c_out=1; (200,100,0) -> s=44, c_out=1.
- Signed overflow: (127,1,0) -> s=128, overflow=1, c_out=0; (128,128,0) -> s=0, overflow=1, c_out=1; (100,27,0) -> s=127, overflow=0.
- Hold and valid:
  - Apply (3,2,0) valid, then drive in_valid=0 with a=b=99 -> s stays 5 and out_valid drops to 0 one cycle later.
  - Back-to-back valids -> each result follows its operands by exactly 1 cycle.
- Reset mid-operation: assert rst at the same edge as a valid (50,50,0) -> after that edge all outputs are 0 and out_valid=0; deassert and reapply -> s=100 one cycle later.
